// File: rtl/sm_cache_node_if.sv
// Processor and directory signal bundle for the single-line MSI cache node.
// The optional counters exist only when SM_CACHE_STATS_EN is defined.
interface sm_cache_node_if #(
    parameter int TAG_W = 4
) ();
    // Processor side
    logic             cpuRead;
    logic             cpuWrite;
    logic [TAG_W-1:0] cpuTag;
    logic             cpuReady;
    logic             cpuDone;

    // Directory side
    logic             fetch;
    logic             invalidateIn;
    logic             dataValueReply;
    logic             readMiss;
    logic             writeMiss;
    logic             writeBack;
    logic [TAG_W-1:0] lineTag;

    // Status
    logic [1:0]       currentState;
    logic             busy;
    logic [2:0]       stateDbg;
`ifdef SM_CACHE_STATS_EN
    logic [15:0]      hitCount;
    logic [15:0]      missCount;
`endif

    // Handshake: a request (cpuRead/cpuWrite) is taken on the rising edge where
    // cpuReady is high; the requester holds it until then. Every pulse output
    // (cpuDone, readMiss, writeMiss, writeBack) lasts exactly one cycle, and
    // lineTag qualifies it. The directory answers a miss with one
    // dataValueReply pulse.
    modport slave (
`ifdef SM_CACHE_STATS_EN
        output hitCount, missCount,
`endif
        input  cpuRead, cpuWrite, cpuTag, fetch, invalidateIn, dataValueReply,
        output cpuReady, cpuDone, readMiss, writeMiss, writeBack, lineTag,
        output currentState, busy, stateDbg
    );

    modport master (
`ifdef SM_CACHE_STATS_EN
        input  hitCount, missCount,
`endif
        output cpuRead, cpuWrite, cpuTag, fetch, invalidateIn, dataValueReply,
        input  cpuReady, cpuDone, readMiss, writeMiss, writeBack, lineTag,
        input  currentState, busy, stateDbg
    );
endinterface

// File: rtl/sm_cache_node.sv
// MSI cache-side coherence controller for one line, with one outstanding miss.
// Defining SM_CACHE_STATS_EN adds saturating hit and miss counters.
module sm_cache_node #(
    parameter int TAG_W = 4
) (
    input logic            clock,
    input logic            reset_n,
    sm_cache_node_if.slave bus
);

    typedef enum logic [2:0] {
        ST_I       = 3'd0,
        ST_S       = 3'd1,
        ST_M       = 3'd2,
        ST_WAIT_RD = 3'd3,
        ST_WAIT_WR = 3'd4,
        ST_WB_PEND = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] line_tag_q, line_tag_d;
    logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
    logic             pend_write_q, pend_write_d;
    logic [1:0]       last_stable_q;
    logic             done_q, done_d;
    logic             rd_miss_q, rd_miss_d;
    logic             wr_miss_q, wr_miss_d;
    logic             wb_q, wb_d;

    logic       stable;
    logic       cpu_ready;
    logic       req;
    logic       tag_hit;
    logic       issue_miss;
    logic [1:0] cur_state;

    assign stable    = (state_q == ST_I) || (state_q == ST_S) || (state_q == ST_M);
    assign cpu_ready = stable && !bus.fetch && !bus.invalidateIn;
    assign req       = cpu_ready && (bus.cpuRead || bus.cpuWrite);
    assign tag_hit   = ((state_q == ST_S) || (state_q == ST_M)) && (bus.cpuTag == line_tag_q);

    always_comb begin
        case (state_q)
            ST_I:    cur_state = 2'b00;
            ST_S:    cur_state = 2'b01;
            ST_M:    cur_state = 2'b10;
            default: cur_state = last_stable_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_I;
            line_tag_q    <= '0;
            pend_tag_q    <= '0;
            pend_write_q  <= 1'b0;
            last_stable_q <= 2'b00;
            done_q        <= 1'b0;
            rd_miss_q     <= 1'b0;
            wr_miss_q     <= 1'b0;
            wb_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_tag_q    <= line_tag_d;
            pend_tag_q    <= pend_tag_d;
            pend_write_q  <= pend_write_d;
            last_stable_q <= cur_state;
            done_q        <= done_d;
            rd_miss_q     <= rd_miss_d;
            wr_miss_q     <= wr_miss_d;
            wb_q          <= wb_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        line_tag_d   = line_tag_q;
        pend_tag_d   = pend_tag_q;
        pend_write_d = pend_write_q;
        done_d       = 1'b0;
        rd_miss_d    = 1'b0;
        wr_miss_d    = 1'b0;
        wb_d         = 1'b0;
        issue_miss   = 1'b0;

        case (state_q)
            ST_I: begin
                if (req) issue_miss = 1'b1;
            end
            ST_S: begin
                if (bus.invalidateIn) begin
                    state_d = ST_I;
                end else if (req) begin
                    // Write hit upgrades; a mismatch silently drops the clean copy.
                    if (tag_hit && !bus.cpuWrite) done_d = 1'b1;
                    else                          issue_miss = 1'b1;
                end
            end
            ST_M: begin
                // Invalidate wins when fetch and invalidate arrive together.
                if (bus.invalidateIn) begin
                    wb_d    = 1'b1;
                    state_d = ST_I;
                end else if (bus.fetch) begin
                    wb_d    = 1'b1;
                    state_d = ST_S;
                end else if (req) begin
                    if (tag_hit) begin
                        done_d = 1'b1;
                    end else begin
                        wb_d         = 1'b1;
                        pend_tag_d   = bus.cpuTag;
                        pend_write_d = bus.cpuWrite;
                        state_d      = ST_WB_PEND;
                    end
                end
            end
            ST_WB_PEND: begin
                line_tag_d = pend_tag_q;
                rd_miss_d  = !pend_write_q;
                wr_miss_d  = pend_write_q;
                state_d    = pend_write_q ? ST_WAIT_WR : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (bus.dataValueReply) begin
                    state_d    = ST_S;
                    line_tag_d = pend_tag_q;
                    done_d     = 1'b1;
                end
            end
            ST_WAIT_WR: begin
                if (bus.dataValueReply) begin
                    state_d = ST_M;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_I;
        endcase

        if (issue_miss) begin
            line_tag_d   = bus.cpuTag;
            pend_tag_d   = bus.cpuTag;
            pend_write_d = bus.cpuWrite;
            rd_miss_d    = !bus.cpuWrite;
            wr_miss_d    = bus.cpuWrite;
            state_d      = bus.cpuWrite ? ST_WAIT_WR : ST_WAIT_RD;
        end
    end

    assign bus.cpuReady     = cpu_ready;
    assign bus.cpuDone      = done_q;
    assign bus.readMiss     = rd_miss_q;
    assign bus.writeMiss    = wr_miss_q;
    assign bus.writeBack    = wb_q;
    assign bus.lineTag      = line_tag_q;
    assign bus.currentState = cur_state;
    assign bus.busy         = !stable;
    assign bus.stateDbg     = state_q;

`ifdef SM_CACHE_STATS_EN
    logic        hit_evt;
    logic        miss_evt;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    assign hit_evt  = req && tag_hit && (!bus.cpuWrite || (state_q == ST_M));
    assign miss_evt = rd_miss_d || wr_miss_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
            if (miss_evt && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign bus.hitCount  = hit_cnt_q;
    assign bus.missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sm_cache_node.sv
// Randomized bench for sm_cache_node: a line-level MSI model predicts every bus
// pulse and completion; a negedge monitor pops and compares them.
module tb_sm_cache_node;

    localparam int TAG_W = 4;
    localparam logic [1:0] EV_WB   = 2'd0;
    localparam logic [1:0] EV_RM   = 2'd1;
    localparam logic [1:0] EV_WM   = 2'd2;
    localparam logic [1:0] EV_DONE = 2'd3;

    logic clock;
    logic reset_n;

    sm_cache_node_if #(.TAG_W(TAG_W)) bus ();

    sm_cache_node #(.TAG_W(TAG_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [TAG_W+1:0] exp_q[$];

    // Reference model: line state 0=I 1=S 2=M plus the held tag
    logic [1:0]       m_state;
    logic [TAG_W-1:0] m_tag;
    int               m_hits;
    int               m_misses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [TAG_W-1:0] tag);
        exp_q.push_back({kind, tag});
    endtask

    task automatic pop_cmp(input logic [1:0] kind);
        logic [TAG_W+1:0] got;
        got = {kind, bus.lineTag};
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pulse: got %0h expected none at %0t", got, $time);
        end else begin
            check("bus_event", got, exp_q.pop_front());
        end
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.writeBack) pop_cmp(EV_WB);
            if (bus.readMiss)  pop_cmp(EV_RM);
            if (bus.writeMiss) pop_cmp(EV_WM);
            if (bus.cpuDone)   pop_cmp(EV_DONE);
        end
    end

    // Acts as the directory until cpuDone is observed
    task automatic wait_done();
        bit done;
        int reply_in;
        done     = 1'b0;
        reply_in = -1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            if (bus.readMiss || bus.writeMiss) begin
                check("busy_in_miss", bus.busy, 1);
                reply_in = $urandom_range(0, 3);
            end
            if (bus.cpuDone) done = 1'b1;
            @(posedge clock); #1;
            bus.dataValueReply = 1'b0;
            if (reply_in == 0) begin
                bus.dataValueReply = 1'b1;
                reply_in = -1;
            end else if (reply_in > 0) begin
                reply_in--;
            end
        end
        bus.dataValueReply = 1'b0;
        check("cpu_done_seen", done, 1);
    endtask

    task automatic cpu_op(input bit wr, input logic [TAG_W-1:0] tag);
        if (m_state != 2'd0 && tag == m_tag && (!wr || m_state == 2'd2)) begin
            push_ev(EV_DONE, m_tag);
            m_hits++;
        end else begin
            if (m_state == 2'd2 && tag != m_tag) push_ev(EV_WB, m_tag);
            push_ev(wr ? EV_WM : EV_RM, tag);
            push_ev(EV_DONE, tag);
            m_misses++;
            m_tag   = tag;
            m_state = wr ? 2'd2 : 2'd1;
        end
        @(posedge clock); #1;
        bus.cpuWrite = wr;
        bus.cpuRead  = !wr;
        bus.cpuTag   = tag;
        #1;
        check("cpu_ready_idle", bus.cpuReady, 1);
        @(posedge clock); #1;
        bus.cpuRead  = 1'b0;
        bus.cpuWrite = 1'b0;
        wait_done();
        check("state_after_op", bus.currentState, m_state);
        check("busy_after_op", bus.busy, 0);
    endtask

    task automatic remote(input bit f, input bit inv);
        if (m_state == 2'd2 && (f || inv)) push_ev(EV_WB, m_tag);
        if (inv) m_state = 2'd0;
        else if (f && m_state == 2'd2) m_state = 2'd1;
        @(posedge clock); #1;
        bus.fetch        = f;
        bus.invalidateIn = inv;
        #1;
        check("cpu_ready_remote", bus.cpuReady, 0);
        @(posedge clock); #1;
        bus.fetch        = 1'b0;
        bus.invalidateIn = 1'b0;
        check("state_after_remote", bus.currentState, m_state);
        @(negedge clock);
    endtask

    initial begin
        bit got_wm;
        logic [TAG_W-1:0] t;
        bus.cpuRead = 1'b0;
        bus.cpuWrite = 1'b0;
        bus.cpuTag = '0;
        bus.fetch = 1'b0;
        bus.invalidateIn = 1'b0;
        bus.dataValueReply = 1'b0;
        m_state = 2'd0;
        m_tag = '0;
        m_hits = 0;
        m_misses = 0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", bus.currentState, 0);
        check("rst_tag", bus.lineTag, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pulses", {bus.cpuDone, bus.readMiss, bus.writeMiss, bus.writeBack}, 0);
        check("rst_ready", bus.cpuReady, 1);
        reset_n = 1'b1;

        // Directed walk through the main transitions
        cpu_op(1'b0, 4'd3);
        cpu_op(1'b1, 4'd3);
        cpu_op(1'b0, 4'd3);
        cpu_op(1'b0, 4'd5);
        check("tag_after_replace", bus.lineTag, 5);
        cpu_op(1'b1, 4'd5);
        remote(1'b1, 1'b0);
        remote(1'b0, 1'b1);
        cpu_op(1'b1, 4'd2);
        remote(1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            t = 4'($urandom_range(0, 3));
            if (r <= 3)      cpu_op(1'b0, t);
            else if (r <= 6) cpu_op(1'b1, t);
            else if (r == 7) remote(1'b1, 1'b0);
            else if (r == 8) remote(1'b0, 1'b1);
            else             remote(1'b1, 1'b1);
        end

        // Invalidate collides with a read in S: request waits one cycle
        cpu_op(1'b0, 4'd7);
        @(posedge clock); #1;
        bus.cpuRead = 1'b1;
        bus.cpuTag = 4'd7;
        bus.invalidateIn = 1'b1;
        #1;
        check("collide_ready", bus.cpuReady, 0);
        @(posedge clock); #1;
        bus.invalidateIn = 1'b0;
        m_state = 2'd0;
        push_ev(EV_RM, 4'd7);
        push_ev(EV_DONE, 4'd7);
        m_misses++;
        m_state = 2'd1;
        m_tag = 4'd7;
        @(negedge clock);
        check("collide_state_i", bus.currentState, 0);
        check("collide_no_rm", bus.readMiss, 0);
        @(posedge clock); #1;
        bus.cpuRead = 1'b0;
        wait_done();
        check("collide_state_s", bus.currentState, 1);

`ifdef SM_CACHE_STATS_EN
        check("hit_count", bus.hitCount, m_hits);
        check("miss_count", bus.missCount, m_misses);
`endif

        // Reset while waiting for a write reply
        remote(1'b0, 1'b1);
        push_ev(EV_WM, 4'd9);
        @(posedge clock); #1;
        bus.cpuWrite = 1'b1;
        bus.cpuTag = 4'd9;
        @(posedge clock); #1;
        bus.cpuWrite = 1'b0;
        got_wm = 1'b0;
        for (int c = 0; c < 10 && !got_wm; c++) begin
            @(negedge clock);
            if (bus.writeMiss) got_wm = 1'b1;
        end
        check("rst_mid_wm_seen", got_wm, 1);
        check("rst_mid_busy_before", bus.busy, 1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_state", bus.currentState, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_tag", bus.lineTag, 0);
`ifdef SM_CACHE_STATS_EN
        check("rst_hit_count", bus.hitCount, 0);
        check("rst_miss_count", bus.missCount, 0);
`endif
        bus.dataValueReply = 1'b1;
        @(posedge clock); #1;
        bus.dataValueReply = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("post_rst_state", bus.currentState, 0);
        check("post_rst_no_done", bus.cpuDone, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sm_cache_node.md
Name: sm_cache_node

Overview:
- Cache-side (requesting node) MSI coherence controller for a single cache line.
- Pairs with the directory state machine:
  - drives readMiss / writeMiss / writeBack toward the directory;
  - consumes fetch / invalidate / dataValueReply from it.
- Accepts processor read/write requests, resolves hits locally, and issues misses, upgrades and replacement write-backs with one outstanding transaction.

Parameters:
TAG_W, 4, width of the block tag held by the line and carried on lineTag.

Ports:
clock  input  1  system clock, all state changes on posedge
reset_n  input  1  asynchronous, active-low reset
cpuRead  input  1  processor read request for cpuTag
cpuWrite  input  1  processor write request for cpuTag (wins over cpuRead if both high)
cpuTag  input  TAG_W  block tag of processor request
cpuReady  output  1  combinational; request accepted on posedge when high
cpuDone  output  1  registered 1-cycle pulse: request completed
fetch  input  1  directory asks owner to supply block
invalidateIn  input  1  directory invalidates local copy
dataValueReply  input  1  directory data reply for outstanding miss
readMiss  output  1  registered 1-cycle pulse to directory
writeMiss  output  1  registered 1-cycle pulse to directory
writeBack  output  1  registered 1-cycle pulse to directory
lineTag  output  TAG_W  tag qualifying current bus pulse / held tag
currentState  output  2  stable line state: 00 I, 01 S, 10 M
busy  output  1  high in transient states

Behaviour:
- Reset (async, reset_n=0): state I, lineTag=0, pending regs=0, all pulse outputs 0, busy=0.
- Internal states:
  - stable: I, S, M;
  - transient: WAIT_RD, WAIT_WR, WB_PEND.
- currentState encoding:
  - reports the stable state;
  - holds the last stable value while in a transient state.
- All pulse outputs default to 0 every cycle; each is asserted for exactly one cycle.
- cpuReady = stable state && !fetch && !invalidateIn.
- Remote events in stable states (take priority over processor requests; same-cycle request not accepted):
  - S + invalidateIn -> I.
  - M + fetch -> writeBack pulse with lineTag, -> S.
  - M + invalidateIn -> writeBack pulse, -> I.
  - I + any remote event -> ignored.
  - fetch and invalidateIn together in M -> treat as invalidate (one writeBack pulse, -> I).
- Processor request on accept; hit = tag match in S/M:
  - Read hit (S or M): cpuDone next cycle; state unchanged.
  - Write hit in M: cpuDone next cycle.
  - Write hit in S (upgrade): writeMiss pulse with lineTag=cpuTag, -> WAIT_WR.
  - Miss in I, or tag mismatch in S (silent drop): readMiss or writeMiss pulse with lineTag=cpuTag, -> WAIT_RD / WAIT_WR.
  - Tag mismatch in M:
    - writeBack pulse with old lineTag;
    - latch pendTag/pendWrite, -> WB_PEND;
    - next cycle: readMiss or writeMiss with pendTag, -> WAIT_RD / WAIT_WR.
- Transient states:
  - WAIT_RD + dataValueReply -> S, cpuDone pulse, lineTag=pendTag.
  - WAIT_WR + dataValueReply -> M, cpuDone pulse.
  - fetch / invalidateIn in transient states are ignored (directory serializes).
  - cpuRead / cpuWrite while cpuReady=0 are ignored; the processor holds them until accepted.
- Latency:
  - hit: 1 cycle;
  - miss: 1 cycle issue + directory reply + 1;
  - dirty replacement: +1 cycle.
- Reset mid-transaction: returns to I immediately; the pending request is dropped with no cpuDone.

Optional Feature:
- Macro: SM_CACHE_STATS_EN.
- When defined, adds outputs:
  - hitCount [15:0]: increments on each accepted hit;
  - missCount [15:0]: increments on each readMiss/writeMiss issued, including upgrades.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, cpuRead tag 3 -> readMiss pulse lineTag=3, busy=1; dataValueReply -> cpuDone, currentState=01, busy=0.
- In S tag 3, cpuWrite tag 3 -> writeMiss pulse lineTag=3; reply -> currentState=10; next cpuRead tag 3 -> cpuDone after 1 cycle, no bus pulses.
- In M tag 3, cpuRead tag 5 -> writeBack lineTag=3, next cycle readMiss lineTag=5; reply -> S, lineTag=5.
- In M, fetch -> writeBack pulse, currentState=01; then invalidateIn -> currentState=00, no pulse.
- invalidateIn and cpuRead same cycle in S -> cpuReady=0, state I, no readMiss until request re-sampled next cycle.
- reset_n low while in WAIT_WR -> currentState=00, busy=0, no cpuDone; SM_CACHE_STATS_EN build: counters read 0.
